// File: rtl/pts_serializer.sv
// Parallel-to-serial converter: takes an N x W-bit word over valid/ready and emits one lane per beat.
// A one-word pending buffer behind the shift stage keeps back-to-back words gap-free.
module pts_serializer #(
    parameter int W  = 8,
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N*W-1:0] in_data,
    input  logic           order,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   out_data,
    output logic [IW-1:0]  out_idx,
    output logic           out_last,
    output logic           busy
);

    // State bits are {sv, pv}; the (0,1) combination has no encoding.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b10,
        ST_FULL  = 2'b11
    } state_e;

    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    state_e              state_q, state_d;
    logic [IW-1:0]       cnt_q, cnt_d;
    logic [N-1:0][W-1:0] sh_word_q, sh_word_d;
    logic [N-1:0][W-1:0] pd_word_q, pd_word_d;
    logic                sh_ord_q, sh_ord_d;
    logic                pd_ord_q, pd_ord_d;

    logic                sv;
    logic                accept;
    logic                consume;
    logic                at_last;
    logic [IW-1:0]       lane_sel;

    assign sv       = (state_q != ST_IDLE);
    assign in_ready = rst && (state_q != ST_FULL);
    assign accept   = in_valid && in_ready;
    assign consume  = sv && out_ready;
    assign at_last  = (cnt_q == LAST_IDX);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sh_word_d = sh_word_q;
        sh_ord_d  = sh_ord_q;
        pd_word_d = pd_word_q;
        pd_ord_d  = pd_ord_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    sh_word_d = in_data;
                    sh_ord_d  = order;
                    cnt_d     = '0;
                    state_d   = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                if (consume && !at_last) begin
                    cnt_d = cnt_q + IW'(1);
                end
                if (accept) begin
                    // A word arriving as the last beat leaves goes straight to the shift stage.
                    if (consume && at_last) begin
                        sh_word_d = in_data;
                        sh_ord_d  = order;
                        cnt_d     = '0;
                    end else begin
                        pd_word_d = in_data;
                        pd_ord_d  = order;
                        state_d   = ST_FULL;
                    end
                end else if (consume && at_last) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end

            ST_FULL: begin
                if (consume) begin
                    if (!at_last) begin
                        cnt_d = cnt_q + IW'(1);
                    end else begin
                        sh_word_d = pd_word_q;
                        sh_ord_d  = pd_ord_q;
                        cnt_d     = '0;
                        state_d   = ST_SHIFT;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            sh_word_q <= '0;
            sh_ord_q  <= 1'b0;
            pd_word_q <= '0;
            pd_ord_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sh_word_q <= sh_word_d;
            sh_ord_q  <= sh_ord_d;
            pd_word_q <= pd_word_d;
            pd_ord_q  <= pd_ord_d;
        end
    end

    // Output mux draws only on registered state, so no in_* to out_* path exists.
    assign lane_sel  = sh_ord_q ? (LAST_IDX - cnt_q) : cnt_q;
    assign out_data  = sv ? sh_word_q[lane_sel] : '0;
    assign out_valid = sv;
    assign out_idx   = cnt_q;
    assign out_last  = sv && at_last;
    assign busy      = sv;

    state_legal : assert property (@(posedge clk) disable iff (!rst)
        state_q inside {ST_IDLE, ST_SHIFT, ST_FULL});

endmodule

// File: tb/tb_pts_serializer.sv
// Bench for pts_serializer: directed scenarios plus randomized traffic checked against a beat-queue model.
// Three instances cover N=4/W=8, N=1/W=16 and N=16/W=8.
module tb_pts_serializer;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    logic         a_in_valid, a_in_ready, a_order, a_out_valid, a_out_ready, a_out_last, a_busy;
    logic [31:0]  a_in_data;
    logic [7:0]   a_out_data;
    logic [1:0]   a_out_idx;

    logic         b_in_valid, b_in_ready, b_order, b_out_valid, b_out_ready, b_out_last, b_busy;
    logic [15:0]  b_in_data;
    logic [15:0]  b_out_data;
    logic [0:0]   b_out_idx;

    logic         c_in_valid, c_in_ready, c_order, c_out_valid, c_out_ready, c_out_last, c_busy;
    logic [127:0] c_in_data;
    logic [7:0]   c_out_data;
    logic [3:0]   c_out_idx;

    pts_serializer #(.W(8), .N(4)) dut_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .order(a_order),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .out_idx(a_out_idx), .out_last(a_out_last), .busy(a_busy)
    );

    pts_serializer #(.W(16), .N(1)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .order(b_order),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_idx(b_out_idx), .out_last(b_out_last), .busy(b_busy)
    );

    pts_serializer #(.W(8), .N(16)) dut_c (
        .clk(clk), .rst(rst),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data), .order(c_order),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
        .out_idx(c_out_idx), .out_last(c_out_last), .busy(c_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, bench did not finish");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        #3;
        total++;
        if (a_out_valid !== 1'b0 || a_out_data !== 8'h00 || a_out_idx !== 2'd0 ||
            a_out_last !== 1'b0 || a_busy !== 1'b0 || a_in_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_a: got v=%b d=%h i=%0d l=%b busy=%b rdy=%b, want all 0",
                     a_out_valid, a_out_data, a_out_idx, a_out_last, a_busy, a_in_ready);
        end
        total++;
        if (b_out_valid !== 1'b0 || b_busy !== 1'b0 || b_in_ready !== 1'b0 ||
            c_out_valid !== 1'b0 || c_busy !== 1'b0 || c_in_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_bc: got b v/busy/rdy=%b%b%b c v/busy/rdy=%b%b%b, want 000",
                     b_out_valid, b_busy, b_in_ready, c_out_valid, c_busy, c_in_ready);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: got rdy=%b v=%b, want rdy=1 v=0", a_in_ready, a_out_valid);
        end
    endtask

    task automatic test_single(input logic [31:0] word, input logic ord);
        int         lane;
        logic [7:0] exp_b;
        @(negedge clk);
        a_in_valid  = 1'b1;
        a_in_data   = word;
        a_order     = ord;
        a_out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            a_in_valid = 1'b0;
            a_order    = ~ord;
            lane  = ord ? 3 - k : k;
            exp_b = 8'(word >> (8 * lane));
            total++;
            if (a_out_valid !== 1'b1 || a_out_data !== exp_b || a_out_idx !== 2'(k) ||
                a_out_last !== (k == 3)) begin
                bad++;
                $display("FAIL single_ord%0d beat%0d: got v=%b d=%h i=%0d l=%b, want v=1 d=%h i=%0d l=%b",
                         ord, k, a_out_valid, a_out_data, a_out_idx, a_out_last, exp_b, k, (k == 3));
            end
        end
        @(negedge clk);
        total++;
        if (a_out_valid !== 1'b0 || a_busy !== 1'b0) begin
            bad++;
            $display("FAIL single_ord%0d idle: got v=%b busy=%b, want 0 0", ord, a_out_valid, a_busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_d [8] = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h77, 8'h66, 8'h55, 8'h44};
        logic       exp_r [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        @(negedge clk);
        a_in_valid  = 1'b1;
        a_in_data   = 32'h33221100;
        a_order     = 1'b0;
        a_out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            total++;
            if (a_out_valid !== 1'b1 || a_out_data !== exp_d[k] || a_out_idx !== 2'(k % 4) ||
                a_out_last !== ((k % 4) == 3) || a_in_ready !== exp_r[k]) begin
                bad++;
                $display("FAIL b2b beat%0d: got v=%b d=%h i=%0d l=%b rdy=%b, want v=1 d=%h i=%0d l=%b rdy=%b",
                         k, a_out_valid, a_out_data, a_out_idx, a_out_last, a_in_ready,
                         exp_d[k], k % 4, ((k % 4) == 3), exp_r[k]);
            end
            if (k == 0) begin
                a_in_data = 32'h77665544;
                a_order   = 1'b1;
            end else begin
                a_in_valid = 1'b0;
            end
        end
        @(negedge clk);
        total++;
        if (a_out_valid !== 1'b0 || a_busy !== 1'b0) begin
            bad++;
            $display("FAIL b2b idle: got v=%b busy=%b, want 0 0", a_out_valid, a_busy);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp_d [7] = '{8'h00, 8'h11, 8'h11, 8'h11, 8'h11, 8'h22, 8'h33};
        int         exp_i [7] = '{0, 1, 1, 1, 1, 2, 3};
        logic       rdy   [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        @(negedge clk);
        a_in_valid  = 1'b1;
        a_in_data   = 32'h33221100;
        a_order     = 1'b0;
        a_out_ready = 1'b1;
        for (int j = 0; j < 7; j++) begin
            @(negedge clk);
            a_in_valid = 1'b0;
            total++;
            if (a_out_valid !== 1'b1 || a_out_data !== exp_d[j] || a_out_idx !== 2'(exp_i[j]) ||
                a_out_last !== (exp_i[j] == 3)) begin
                bad++;
                $display("FAIL backpressure step%0d: got v=%b d=%h i=%0d l=%b, want v=1 d=%h i=%0d l=%b",
                         j, a_out_valid, a_out_data, a_out_idx, a_out_last, exp_d[j], exp_i[j], (exp_i[j] == 3));
            end
            a_out_ready = rdy[j];
        end
        @(negedge clk);
        total++;
        if (a_out_valid !== 1'b0 || a_busy !== 1'b0) begin
            bad++;
            $display("FAIL backpressure idle: got v=%b busy=%b, want 0 0", a_out_valid, a_busy);
        end
    endtask

    task automatic test_reset_mid_word();
        logic [7:0] exp_d [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        @(negedge clk);
        a_in_valid  = 1'b1;
        a_in_data   = 32'h33221100;
        a_order     = 1'b0;
        a_out_ready = 1'b1;
        @(negedge clk);
        a_in_data = 32'h77665544;
        a_order   = 1'b1;
        @(negedge clk);
        a_in_valid = 1'b0;
        total++;
        if (a_out_data !== 8'h11 || a_busy !== 1'b1 || a_in_ready !== 1'b0) begin
            bad++;
            $display("FAIL rstmid pre: got d=%h busy=%b rdy=%b, want d=11 busy=1 rdy=0",
                     a_out_data, a_busy, a_in_ready);
        end
        #2;
        rst = 1'b0;
        #1;
        total++;
        if (a_out_valid !== 1'b0 || a_out_data !== 8'h00 || a_out_idx !== 2'd0 ||
            a_out_last !== 1'b0 || a_busy !== 1'b0 || a_in_ready !== 1'b0) begin
            bad++;
            $display("FAIL rstmid async: got v=%b d=%h i=%0d l=%b busy=%b rdy=%b, want all 0",
                     a_out_valid, a_out_data, a_out_idx, a_out_last, a_busy, a_in_ready);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if (a_out_valid !== 1'b0 || a_busy !== 1'b0 || a_in_ready !== 1'b1) begin
            bad++;
            $display("FAIL rstmid release: got v=%b busy=%b rdy=%b, want v=0 busy=0 rdy=1",
                     a_out_valid, a_busy, a_in_ready);
        end
        @(negedge clk);
        total++;
        if (a_out_valid !== 1'b0) begin
            bad++;
            $display("FAIL rstmid stray: got v=%b d=%h, want v=0", a_out_valid, a_out_data);
        end
        a_in_valid = 1'b1;
        a_in_data  = 32'hDDCCBBAA;
        a_order    = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            a_in_valid = 1'b0;
            total++;
            if (a_out_valid !== 1'b1 || a_out_data !== exp_d[k] || a_out_idx !== 2'(k) ||
                a_out_last !== (k == 3)) begin
                bad++;
                $display("FAIL rstmid beat%0d: got v=%b d=%h i=%0d l=%b, want v=1 d=%h i=%0d l=%b",
                         k, a_out_valid, a_out_data, a_out_idx, a_out_last, exp_d[k], k, (k == 3));
            end
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [7:0] qd[$];
        int         qi[$];
        int         b;
        int         lane;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            b = qd.size();
            total++;
            if (a_out_valid !== (b > 0) || a_busy !== (b > 0) || a_in_ready !== (b <= 4)) begin
                bad++;
                $display("FAIL random ctl cyc%0d: got v=%b busy=%b rdy=%b, want v=%b busy=%b rdy=%b",
                         cyc, a_out_valid, a_busy, a_in_ready, (b > 0), (b > 0), (b <= 4));
            end
            if (b > 0) begin
                total++;
                if (a_out_data !== qd[0] || a_out_idx !== 2'(qi[0]) || a_out_last !== (qi[0] == 3)) begin
                    bad++;
                    $display("FAIL random beat cyc%0d: got d=%h i=%0d l=%b, want d=%h i=%0d l=%b",
                             cyc, a_out_data, a_out_idx, a_out_last, qd[0], qi[0], (qi[0] == 3));
                end
            end
            a_in_valid  = (cyc < 560) && ($urandom_range(0, 3) != 0);
            a_in_data   = $urandom;
            a_order     = 1'($urandom_range(0, 1));
            a_out_ready = (cyc >= 560) || ($urandom_range(0, 3) != 0);
            if (b > 0 && a_out_ready) begin
                void'(qd.pop_front());
                void'(qi.pop_front());
            end
            if (a_in_valid && b <= 4) begin
                for (int k = 0; k < 4; k++) begin
                    lane = a_order ? 3 - k : k;
                    qd.push_back(a_in_data[8 * lane +: 8]);
                    qi.push_back(k);
                end
            end
        end
        a_in_valid = 1'b0;
        @(negedge clk);
        total++;
        if (a_busy !== 1'b0 || qd.size() != 0) begin
            bad++;
            $display("FAIL random drain: got busy=%b, want 0 (model has %0d beats left)", a_busy, qd.size());
        end
    endtask

    task automatic test_sweep_n1();
        logic [15:0] words [2] = '{16'hBEEF, 16'h1234};
        @(negedge clk);
        b_in_valid  = 1'b1;
        b_in_data   = words[0];
        b_order     = 1'b1;
        b_out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            total++;
            if (b_out_valid !== 1'b1 || b_out_data !== words[k] || b_out_idx !== 1'b0 ||
                b_out_last !== 1'b1) begin
                bad++;
                $display("FAIL n1 beat%0d: got v=%b d=%h i=%0d l=%b, want v=1 d=%h i=0 l=1",
                         k, b_out_valid, b_out_data, b_out_idx, b_out_last, words[k]);
            end
            if (k == 0) begin
                b_in_data = words[1];
                b_order   = 1'b0;
            end else begin
                b_in_valid = 1'b0;
            end
        end
        @(negedge clk);
        total++;
        if (b_out_valid !== 1'b0 || b_busy !== 1'b0) begin
            bad++;
            $display("FAIL n1 idle: got v=%b busy=%b, want 0 0", b_out_valid, b_busy);
        end
    endtask

    task automatic test_sweep_n16();
        logic [127:0] blk;
        logic [7:0]   exp_b;
        int           lane;
        blk = {$urandom, $urandom, $urandom, $urandom};
        for (int ord = 0; ord < 2; ord++) begin
            @(negedge clk);
            c_in_valid  = 1'b1;
            c_in_data   = blk;
            c_order     = 1'(ord);
            c_out_ready = 1'b1;
            for (int k = 0; k < 16; k++) begin
                @(negedge clk);
                c_in_valid = 1'b0;
                lane  = (ord == 1) ? 15 - k : k;
                exp_b = blk[8 * lane +: 8];
                total++;
                if (c_out_valid !== 1'b1 || c_out_data !== exp_b || c_out_idx !== 4'(k) ||
                    c_out_last !== (k == 15)) begin
                    bad++;
                    $display("FAIL n16_ord%0d beat%0d: got v=%b d=%h i=%0d l=%b, want v=1 d=%h i=%0d l=%b",
                             ord, k, c_out_valid, c_out_data, c_out_idx, c_out_last, exp_b, k, (k == 15));
                end
            end
            @(negedge clk);
            total++;
            if (c_out_valid !== 1'b0 || c_busy !== 1'b0) begin
                bad++;
                $display("FAIL n16_ord%0d idle: got v=%b busy=%b, want 0 0", ord, c_out_valid, c_busy);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        a_in_valid = 1'b0; a_in_data = '0; a_order = 1'b0; a_out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_data = '0; b_order = 1'b0; b_out_ready = 1'b0;
        c_in_valid = 1'b0; c_in_data = '0; c_order = 1'b0; c_out_ready = 1'b0;

        test_reset();
        test_single(32'h33221100, 1'b0);
        test_single(32'h33221100, 1'b1);
        test_back_to_back();
        test_backpressure();
        test_reset_mid_word();
        test_random();
        test_sweep_n1();
        test_sweep_n16();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
